// File: rtl/bayer_mosaic_pkg.sv
// rtl/bayer_mosaic_pkg.sv - shared constants and types for the Bayer mosaic streamer
package bayer_mosaic_pkg;

   localparam int DEF_IMG_LOG2 = 7;
   localparam logic [13:0] LAST_PIX = 14'd16383;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FETCH = 2'd1,
      S_DRAIN = 2'd2,
      S_FIN   = 2'd3
   } state_t;

   // Phase tag is {row[0], col[0]} of the fetched pixel.
   typedef enum logic [1:0] {
      PH_G0 = 2'b00,
      PH_R  = 2'b01,
      PH_B  = 2'b10,
      PH_G1 = 2'b11
   } phase_t;

   function automatic phase_t pixel_phase(input logic row_lsb, input logic col_lsb);
      return phase_t'({row_lsb, col_lsb});
   endfunction

endpackage

// File: rtl/bayer_mosaic_fifo2.sv
// rtl/bayer_mosaic_fifo2.sv - two-entry {last, data} output FIFO with a registered head
module mosaic_fifo2 (
   input  logic       clk,
   input  logic       reset,
   input  logic       push,
   input  logic [8:0] push_data,
   input  logic       pop,
   output logic [8:0] head,
   output logic [1:0] count,
   output logic       full,
   output logic       empty
);

   logic [8:0] tail;
   logic       do_pop;

   assign full   = (count == 2'd2);
   assign empty  = (count == 2'd0);
   assign do_pop = pop & ~empty;

   always_ff @(posedge clk) begin
      if (reset) begin
         count <= 2'd0;
         head  <= 9'd0;
         tail  <= 9'd0;
      end else begin
         case ({push, do_pop})
            2'b10: begin
               if (count == 2'd0) begin
                  head  <= push_data;
                  count <= 2'd1;
               end else if (count == 2'd1) begin
                  tail  <= push_data;
                  count <= 2'd2;
               end
            end
            2'b01: begin
               if (count == 2'd2)
                  head <= tail;
               count <= count - 2'd1;
            end
            2'b11: begin
               // Occupancy is unchanged; only the entries shift.
               if (count == 2'd2) begin
                  head <= tail;
                  tail <= push_data;
               end else begin
                  head <= push_data;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/bayer_mosaic.sv
// rtl/bayer_mosaic.sv - streams R/G/B planes out as a G R / B G Bayer pixel stream
module bayer_mosaic
   import bayer_mosaic_pkg::*;
#(
   parameter int IMG_LOG2 = DEF_IMG_LOG2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   output logic                  busy,
   output logic [2*IMG_LOG2-1:0] addr_r,
   output logic [2*IMG_LOG2-1:0] addr_g,
   output logic [2*IMG_LOG2-1:0] addr_b,
   input  logic [7:0]            rdata_r,
   input  logic [7:0]            rdata_g,
   input  logic [7:0]            rdata_b,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [7:0]            data_out,
   output logic                  out_last,
   output logic                  done
);

   localparam int AW = 2 * IMG_LOG2;
   localparam logic [AW-1:0] LAST_ADDR = {AW{1'b1}};

   state_t          state;
   logic [AW-1:0]   pix_cnt;
   logic [AW-1:0]   addr;
   phase_t          phase_q;
   logic            last_q;
   logic            inflight;

   logic            issue;
   logic            pop;
   logic            drained;
   logic [7:0]      sample;
   logic [8:0]      fifo_head;
   logic [1:0]      fifo_count;
   logic            fifo_full;
   logic            fifo_empty;

   assign addr_r    = addr;
   assign addr_g    = addr;
   assign addr_b    = addr;
   assign out_valid = ~fifo_empty;
   assign data_out  = fifo_head[7:0];
   assign out_last  = fifo_head[8];
   assign pop       = out_valid & out_ready;

   // Fetch only while FIFO entries plus the in-flight sample, less this cycle's pop, stay below 2.
   always_comb begin
      issue = 1'b0;
      if (state == S_FETCH)
         issue = fifo_empty
              || (!fifo_full && (!inflight || pop))
              || (fifo_full && !inflight && pop);
   end

   assign drained = !inflight && (fifo_empty || (fifo_count == 2'd1 && pop));

   always_comb begin
      sample = rdata_g;
      case (phase_q)
         PH_R:    sample = rdata_r;
         PH_B:    sample = rdata_b;
         default: sample = rdata_g;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= S_IDLE;
         busy     <= 1'b0;
         done     <= 1'b0;
         pix_cnt  <= '0;
         addr     <= '0;
         phase_q  <= PH_G0;
         last_q   <= 1'b0;
         inflight <= 1'b0;
      end else begin
         done     <= 1'b0;
         inflight <= issue;
         if (issue) begin
            addr    <= pix_cnt;
            phase_q <= pixel_phase(pix_cnt[IMG_LOG2], pix_cnt[0]);
            last_q  <= (pix_cnt == LAST_ADDR);
         end
         case (state)
            S_IDLE: begin
               if (start) begin
                  state   <= S_FETCH;
                  busy    <= 1'b1;
                  pix_cnt <= '0;
               end
            end
            S_FETCH: begin
               if (issue) begin
                  if (pix_cnt == LAST_ADDR)
                     state <= S_DRAIN;
                  else
                     pix_cnt <= pix_cnt + 1'b1;
               end
            end
            S_DRAIN: begin
               if (drained) begin
                  state <= S_FIN;
                  done  <= 1'b1;
               end
            end
            S_FIN: begin
               state <= S_IDLE;
               busy  <= 1'b0;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   mosaic_fifo2 u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (inflight),
      .push_data ({last_q, sample}),
      .pop       (pop),
      .head      (fifo_head),
      .count     (fifo_count),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

endmodule
